// File: rtl/lock_chamber_sequencer.sv
// Water-lock chamber sequencer: close gates, pump one level step per enable tick,
// settle, then open the gate on the side matching the new level.
module lock_chamber_sequencer #(
  parameter int LEVEL_W      = 4,
  parameter int LEVEL_MAX    = 8,
  parameter int CLOSE_TICKS  = 2,
  parameter int SETTLE_TICKS = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               dir,
  output logic [LEVEL_W-1:0] level,
  output logic               fill_valve,
  output logic               drain_valve,
  output logic               upper_open,
  output logic               lower_open,
  output logic               busy,
  output logic               done
);

  localparam int MAX_TICKS = (CLOSE_TICKS > SETTLE_TICKS) ? CLOSE_TICKS : SETTLE_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [LEVEL_W-1:0] LEVEL_TOP   = LEVEL_W'(LEVEL_MAX);
  localparam logic [CNT_W-1:0]   CLOSE_LAST  = CNT_W'(CLOSE_TICKS - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLOSE,
    S_PUMP,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic               dir_q, dir_d;

  logic [LEVEL_W-1:0] start_target;
  logic [LEVEL_W-1:0] pump_target;
  logic [LEVEL_W-1:0] level_step;

  assign start_target = dir   ? '0 : LEVEL_TOP;
  assign pump_target  = dir_q ? '0 : LEVEL_TOP;

  // Saturating step so the level can never leave 0..LEVEL_MAX.
  always_comb begin
    level_step = level_q;
    if (dir_q) begin
      if (level_q != '0) level_step = level_q - 1'b1;
    end else begin
      if (level_q < LEVEL_TOP) level_step = level_q + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    tick_cnt_d = tick_cnt_q;
    dir_d      = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d      = dir;
          tick_cnt_d = '0;
          state_d    = (level_q == start_target) ? S_DONE : S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (enable) begin
          if (tick_cnt_q == CLOSE_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_PUMP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_PUMP: begin
        if (enable) begin
          level_d = level_step;
          if (level_step == pump_target) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (enable) begin
          if (tick_cnt_q == SETTLE_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_DONE;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      tick_cnt_q <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      tick_cnt_q <= tick_cnt_d;
      dir_q      <= dir_d;
    end
  end

  // Outputs decode registered state only; gates open solely when the chamber is at rest.
  assign level       = level_q;
  assign fill_valve  = (state_q == S_PUMP) && !dir_q;
  assign drain_valve = (state_q == S_PUMP) &&  dir_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign upper_open  = ((state_q == S_IDLE) || (state_q == S_DONE)) && (level_q == LEVEL_TOP);
  assign lower_open  = ((state_q == S_IDLE) || (state_q == S_DONE)) && (level_q == '0);

endmodule

// File: tb/tb_lock_chamber_sequencer.sv
// Directed bench for lock_chamber_sequencer: reset, fill, paced drain, no-op,
// ignored start while busy, and a random invariant soak.
module tb_lock_chamber_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, start, dir;
  logic [3:0] level;
  logic       fill_valve, drain_valve, upper_open, lower_open, busy, done;

  int total = 0;
  int bad   = 0;

  lock_chamber_sequencer #(
    .LEVEL_W(4), .LEVEL_MAX(8), .CLOSE_TICKS(2), .SETTLE_TICKS(2)
  ) dut (
    .clock(clk), .reset(reset), .enable(enable), .start(start), .dir(dir),
    .level(level), .fill_valve(fill_valve), .drain_valve(drain_valve),
    .upper_open(upper_open), .lower_open(lower_open), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock edge; inputs set before the call are sampled on it, outputs read 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_lvl, busy_cnt, pulses, cyc, phase, saw_fill, saw_drain, viol;
    logic en_now;

    reset = 1'b1; start = 1'b1; dir = 1'b0; enable = 1'b1;
    step();
    // ---- 1: reset behaviour ----
    check("rst_level", level, 0);
    check("rst_lower", lower_open, 1);
    check("rst_upper", upper_open, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0; start = 1'b1; dir = 1'b0; enable = 1'b1;
    step();
    start = 1'b0;
    check("mid_accept_busy", busy, 1);
    step(); step();              // two CLOSE ticks -> PUMP
    check("mid_pump_fill", fill_valve, 1);
    step(); step(); step();      // now in the 4th PUMP cycle
    check("mid_pump4_level", level, 3);
    reset = 1'b1;
    step();
    reset = 1'b0; enable = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_lower", lower_open, 1);
    step();
    check("mid_rst_nodone", done, 0);

    // ---- 2: fill with enable tied high ----
    enable = 1'b1; start = 1'b1; dir = 1'b0;
    step();
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 13; i++) begin
      exp_lvl = (i <= 3) ? 0 : ((i - 3 > 8) ? 8 : i - 3);
      check($sformatf("fill_lvl_c%0d", i), level, exp_lvl);
      check($sformatf("fill_done_c%0d", i), done, (i == 13) ? 1 : 0);
      check($sformatf("fill_valve_c%0d", i), fill_valve, (i >= 3 && i <= 10) ? 1 : 0);
      check($sformatf("fill_upper_c%0d", i), upper_open, (i == 13) ? 1 : 0);
      if (busy) busy_cnt++;
      step();
    end
    check("fill_busy_cycles", busy_cnt, 13);
    check("fill_idle_busy", busy, 0);
    check("fill_idle_upper", upper_open, 1);
    check("fill_idle_lower", lower_open, 0);

    // ---- 4: no-op fill at the top level ----
    enable = 1'b0; start = 1'b1; dir = 1'b0;
    step();
    start = 1'b0;
    check("noop_done", done, 1);
    check("noop_busy", busy, 1);
    check("noop_level", level, 8);
    check("noop_fill", fill_valve, 0);
    check("noop_upper", upper_open, 1);
    step();
    check("noop_done_clear", done, 0);
    check("noop_busy_clear", busy, 0);
    check("noop_level_hold", level, 8);

    // ---- 3: drain paced by a five-cycle tick; the start-edge tick is not counted ----
    enable = 1'b1; start = 1'b1; dir = 1'b1;
    step();
    start = 1'b0; dir = 1'b0;
    pulses = 0; cyc = 0; phase = 0; saw_fill = 0;
    while (!done && cyc < 200) begin
      en_now = (phase == 4);
      enable = en_now;
      phase  = (phase + 1) % 5;
      step();
      cyc++;
      if (en_now) pulses++;
      if (fill_valve) saw_fill = 1;
      exp_lvl = 8 - ((pulses - 2 < 0) ? 0 : ((pulses - 2 > 8) ? 8 : pulses - 2));
      if (!done) check($sformatf("drain_lvl_p%0d", pulses), level, exp_lvl);
    end
    check("drain_reached_done", done, 1);
    check("drain_pulses", pulses, 12);
    check("drain_no_fill", saw_fill, 0);
    check("drain_done_level", level, 0);
    check("drain_done_lower", lower_open, 1);
    enable = 1'b0;
    step();
    check("drain_idle_busy", busy, 0);
    check("drain_idle_lower", lower_open, 1);

    // ---- 5: start while busy is ignored ----
    enable = 1'b1; start = 1'b1; dir = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();      // into PUMP
    start = 1'b1; dir = 1'b1;
    step();
    start = 1'b0; dir = 1'b0;
    cyc = 0; saw_drain = 0;
    while (!done && cyc < 30) begin
      if (drain_valve) saw_drain = 1;
      step();
      cyc++;
    end
    check("busy_start_done", done, 1);
    check("busy_start_level", level, 8);
    for (int i = 0; i < 6; i++) begin
      if (drain_valve) saw_drain = 1;
      step();
    end
    check("busy_start_no_drain", saw_drain, 0);
    check("busy_start_hold", level, 8);
    check("busy_start_idle", busy, 0);

    // ---- 6: random soak of the safety invariants ----
    viol = 0;
    for (int i = 0; i < 10000; i++) begin
      start  = ($urandom_range(0, 7) == 0);
      dir    = $urandom_range(0, 1) == 1;
      enable = $urandom_range(0, 1) == 1;
      step();
      if (upper_open && lower_open) viol++;
      if ((fill_valve || drain_valve) && (upper_open || lower_open)) viol++;
      if (fill_valve && drain_valve) viol++;
      if (level > 8) viol++;
    end
    check("soak_violations", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
